// File: rtl/counter_poller_pkg.sv
`default_nettype none
// =============================================================================
// counter_poller_pkg : shared types, constants and wrap-delta helper
// Rev 1.0
// =============================================================================
package counter_poller_pkg;

    typedef enum logic [2:0] {
        PRIME  = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        UPDATE = 3'd3,
        WAIT   = 3'd4
    } state_e;

    localparam int         NC         = 4;
    localparam logic [7:0] OVF_THRESH = 8'd96;

    // Modulo-256 difference reinterpreted as a signed step of -128..+127.
    function automatic logic signed [7:0] wrap_delta(input logic [7:0] cur,
                                                     input logic [7:0] prev);
        return signed'(cur - prev);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_poller_unwrap.sv
`default_nettype none
// =============================================================================
// counter_poller_unwrap : 8-bit count to POS_W-bit position unwrap datapath
// Optional magnitude check: COUNTER_POLLER_OVF_EN.  Rev 1.0
// =============================================================================
module counter_poller_unwrap
    import counter_poller_pkg::*;
#(
    parameter int POS_W = 16
) (
    input  logic [7:0]        countin,
    input  logic [7:0]        last,
    input  logic [POS_W-1:0]  pos,
    output logic [POS_W-1:0]  pos_new,
    output logic signed [7:0] delta,
    output logic              over
);

    assign delta   = wrap_delta(countin, last);
    assign pos_new = pos + {{(POS_W-8){delta[7]}}, delta};

`ifdef COUNTER_POLLER_OVF_EN
    logic [7:0] w_mag;
    // -128 maps to 8'h80, which still compares correctly as unsigned 128.
    assign w_mag = delta[7] ? (~delta + 8'd1) : delta;
    assign over  = (w_mag >= OVF_THRESH);
`else
    assign over = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/counter_poller.sv
`default_nettype none
// =============================================================================
// counter_poller : round-robin encoder counter reader with position unwrap
// and host snapshot handshake. Optional flags: COUNTER_POLLER_OVF_EN. Rev 1.0
// =============================================================================
module counter_poller
    import counter_poller_pkg::*;
#(
    parameter int POLL_DIV = 16,
    parameter int POS_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             oe,
    output logic [1:0]       sel,
    input  logic [7:0]       countin,
    input  logic             latch_req,
    output logic             latch_ack,
    input  logic [1:0]       rd_sel,
    output logic [POS_W-1:0] rd_data,
    output logic             busy,
    output logic [3:0]       ovf
);

    localparam int              WAIT_W      = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LOAD = WAIT_W'(POLL_DIV - 1);

    state_e                       r_state;
    logic [1:0]                   r_ch;
    logic [7:0]                   r_cap;
    logic                         r_prime_round;
    logic                         r_pending;
    logic                         r_snap_round;
    logic                         r_ack;
    logic [WAIT_W-1:0]            r_wait_cnt;
    logic [NC-1:0][POS_W-1:0]     r_pos;
    logic [NC-1:0][POS_W-1:0]     r_snap;
    logic [NC-1:0][7:0]           r_last;
    logic [POS_W-1:0]             r_rd_data;

    logic [POS_W-1:0]             w_pos_new;
    logic signed [7:0]            w_delta;
    logic                         w_over;
    logic                         w_update;
    logic                         w_round_end;
    logic                         w_req;

    assign w_update    = (r_state == UPDATE);
    assign w_round_end = w_update && (r_ch == 2'd3);
    assign w_req       = r_pending | latch_req;

    counter_poller_unwrap #(
        .POS_W (POS_W)
    ) u_unwrap (
        .countin (r_cap),
        .last    (r_last[r_ch]),
        .pos     (r_pos[r_ch]),
        .pos_new (w_pos_new),
        .delta   (w_delta),
        .over    (w_over)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= PRIME;
            r_ch          <= 2'd0;
            r_cap         <= 8'd0;
            r_prime_round <= 1'b0;
            r_pending     <= 1'b0;
            r_snap_round  <= 1'b0;
            r_ack         <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_ack <= 1'b0;
            if (latch_req) r_pending <= 1'b1;
            case (r_state)
                PRIME: begin
                    r_state       <= DRIVE;
                    r_ch          <= 2'd0;
                    r_prime_round <= 1'b1;
                end
                DRIVE:  r_state <= SAMPLE;
                SAMPLE: begin
                    r_state <= UPDATE;
                    r_cap   <= countin;
                end
                UPDATE: begin
                    if (r_ch != 2'd3) begin
                        r_ch    <= r_ch + 2'd1;
                        r_state <= DRIVE;
                    end else begin
                        r_ch          <= 2'd0;
                        r_prime_round <= 1'b0;
                        r_snap_round  <= 1'b0;
                        if (r_snap_round) begin
                            r_ack      <= 1'b1;
                            r_state    <= WAIT;
                            r_wait_cnt <= C_WAIT_LOAD;
                        end else if (w_req) begin
                            // The request is consumed into the round that serves it.
                            r_state      <= DRIVE;
                            r_snap_round <= 1'b1;
                            r_pending    <= 1'b0;
                        end else begin
                            r_state    <= WAIT;
                            r_wait_cnt <= C_WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (w_req || (r_wait_cnt == '0)) begin
                        r_state      <= DRIVE;
                        r_snap_round <= w_req;
                        r_pending    <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                default: r_state <= PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos  <= '0;
            r_last <= '0;
            r_snap <= '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (w_update && (r_ch == i[1:0])) begin
                    r_last[i] <= r_cap;
                    if (!r_prime_round) r_pos[i] <= w_pos_new;
                end
                // Channel 3 is updating this cycle, so take its post-update value.
                if (w_round_end && r_snap_round)
                    r_snap[i] <= (r_ch == i[1:0]) ? w_pos_new : r_pos[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= r_snap[rd_sel];
    end

`ifdef COUNTER_POLLER_OVF_EN
    logic [NC-1:0] r_ovf;
    logic [NC-1:0] w_ovf_set;

    assign w_ovf_set = (w_update && !r_prime_round && w_over) ? (NC'(1) << r_ch) : '0;

    always_ff @(posedge clk) begin
        if (rst) r_ovf <= '0;
        else     r_ovf <= (r_ovf & {NC{~r_ack}}) | w_ovf_set;
    end

    assign ovf = r_ovf;
`else
    logic w_unused_over;
    assign w_unused_over = w_over;
    assign ovf           = 4'b0000;
`endif

    logic w_unused_delta;
    assign w_unused_delta = ^w_delta;

    assign oe        = (r_state == DRIVE) || (r_state == SAMPLE);
    assign sel       = r_ch;
    assign busy      = (r_state == DRIVE) || (r_state == SAMPLE) || (r_state == UPDATE);
    assign latch_ack = r_ack;
    assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_counter_poller.sv
`default_nettype none
// =============================================================================
// tb_counter_poller : directed self-checking bench for counter_poller
// Rev 1.0
// =============================================================================
module tb_counter_poller;

    logic        clk;
    logic        rst;
    logic        oe;
    logic [1:0]  sel;
    logic [7:0]  countin;
    logic        latch_req;
    logic        latch_ack;
    logic [1:0]  rd_sel;
    logic [15:0] rd_data;
    logic        busy;
    logic [3:0]  ovf;

    logic [7:0]  cnt [4];
    int          checks;
    int          errors;

`ifdef COUNTER_POLLER_OVF_EN
    localparam logic [3:0] OVF_EXP = 4'b1000;
`else
    localparam logic [3:0] OVF_EXP = 4'b0000;
`endif

    counter_poller #(
        .POLL_DIV (16),
        .POS_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .oe        (oe),
        .sel       (sel),
        .countin   (countin),
        .latch_req (latch_req),
        .latch_ack (latch_ack),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder counter read port: one-cycle latency behind oe/sel.
    initial countin = 8'd0;
    always @(posedge clk) if (oe) countin <= cnt[sel];

    task automatic wait_busy(input logic val);
        int n = 0;
        while (busy !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== val) begin
            errors++;
            $display("FAIL wait_busy: busy=%b required %b within 200 cycles", busy, val);
        end
    endtask

    task automatic wait_round();
        wait_busy(1'b0);
        wait_busy(1'b1);
        wait_busy(1'b0);
    endtask

    task automatic do_reset(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
        @(negedge clk);
        rst = 1'b1; latch_req = 1'b0;
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_round();
    endtask

    task automatic req_snap(output int lat);
        lat = -1;
        latch_req = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            latch_req = 1'b0;
            if (latch_ack === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic read_snap(input logic [1:0] ch, output logic [15:0] val);
        rd_sel = ch;
        @(negedge clk);
        val = rd_data;
    endtask

    task automatic test_reset();
        int          lat;
        logic [15:0] v;
        @(negedge clk);
        rst = 1'b1; latch_req = 1'b0; rd_sel = 2'd0;
        for (int i = 0; i < 4; i++) cnt[i] = 8'h05;
        repeat (2) @(negedge clk);
        checks++;
        if ({oe, sel, latch_ack, busy, ovf, rd_data} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: oe=%b sel=%0d ack=%b busy=%b ovf=%b rd=%h required all 0",
                     oe, sel, latch_ack, busy, ovf, rd_data);
        end
        rst = 1'b0;
        wait_busy(1'b1);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({oe, sel, busy} !== {(k % 3) != 2, 2'(k / 3), 1'b1}) begin
                errors++;
                $display("FAIL prime_trace k=%0d: oe=%b sel=%0d busy=%b required oe=%b sel=%0d busy=1",
                         k, oe, sel, busy, (k % 3) != 2, k / 3);
            end
            @(negedge clk);
        end
        checks++;
        if ({oe, busy} !== 2'b00) begin
            errors++;
            $display("FAIL round_end: oe=%b busy=%b required 0 0", oe, busy);
        end
        req_snap(lat);
        checks++;
        if (lat != 13) begin
            errors++;
            $display("FAIL prime_snap_latency: got %0d required 13", lat);
        end
        for (int i = 0; i < 4; i++) begin
            read_snap(2'(i), v);
            checks++;
            if (v !== 16'h0000) begin
                errors++;
                $display("FAIL static_pos ch%0d: got %h required 0000", i, v);
            end
        end
    endtask

    task automatic test_wrap();
        int          lat;
        logic [15:0] v;
        do_reset(8'h05, 8'hF0, 8'h05, 8'h05);
        cnt[1] = 8'h10;
        wait_round();
        req_snap(lat);
        read_snap(2'd1, v);
        checks++;
        if (v !== 16'h0020) begin
            errors++;
            $display("FAIL wrap_up: pos1 got %h required 0020", v);
        end
        read_snap(2'd0, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_other_ch: pos0 got %h required 0000", v);
        end
        cnt[1] = 8'hF0;
        req_snap(lat);
        read_snap(2'd1, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_down: pos1 got %h required 0000", v);
        end
    endtask

    task automatic test_latch_wait();
        int          ack_k;
        logic [15:0] v;
        logic        busy_next;
        do_reset(8'h05, 8'h05, 8'h05, 8'h05);
        cnt[2] = 8'h0C;
        ack_k = -1;
        busy_next = 1'b0;
        latch_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            latch_req = 1'b0;
            if (k == 1) busy_next = busy;
            if (latch_ack === 1'b1) begin
                ack_k = k;
                break;
            end
        end
        checks++;
        if (busy_next !== 1'b1) begin
            errors++;
            $display("FAIL wait_abort: busy after request got %b required 1", busy_next);
        end
        checks++;
        if (ack_k != 13) begin
            errors++;
            $display("FAIL ack_latency_wait: got %0d required 13", ack_k);
        end
        read_snap(2'd2, v);
        checks++;
        if (v !== 16'h0007) begin
            errors++;
            $display("FAIL rd_sel2: got %h required 0007", v);
        end
    endtask

    task automatic test_back_to_back();
        int          ack_k;
        logic        gap;
        logic [15:0] v;
        do_reset(8'h05, 8'h05, 8'h05, 8'h05);
        cnt[3] = 8'h20;
        wait_busy(1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if ({oe, sel} !== 3'b110) begin
            errors++;
            $display("FAIL ch2_position: oe=%b sel=%0d required oe=1 sel=2", oe, sel);
        end
        latch_req = 1'b1;
        ack_k = -1;
        gap = 1'b0;
        for (int k = 7; k <= 40; k++) begin
            @(negedge clk);
            latch_req = 1'b0;
            if (k == 12) cnt[3] = 8'h25;
            if (k <= 23 && busy !== 1'b1) gap = 1'b1;
            if (latch_ack === 1'b1) begin
                ack_k = k;
                break;
            end
        end
        checks++;
        if (gap !== 1'b0) begin
            errors++;
            $display("FAIL no_wait_gap: busy dropped between rounds, required continuous");
        end
        checks++;
        if (ack_k != 24) begin
            errors++;
            $display("FAIL ack_after_second_round: got cycle %0d required 24", ack_k);
        end
        read_snap(2'd3, v);
        checks++;
        if (v !== 16'h0020) begin
            errors++;
            $display("FAIL snap_post_update: pos3 got %h required 0020", v);
        end
    endtask

    task automatic test_no_saturate();
        int          lat;
        logic [15:0] v;
        do_reset(8'h00, 8'h00, 8'h00, 8'h00);
        for (int r = 0; r < 258; r++) begin
            cnt[0] = cnt[0] + ((r < 257) ? 8'd127 : 8'd113);
            wait_round();
        end
        req_snap(lat);
        read_snap(2'd0, v);
        checks++;
        if (v !== 16'h7FF0) begin
            errors++;
            $display("FAIL pos_accumulate: pos0 got %h required 7ff0", v);
        end
        cnt[0] = cnt[0] + 8'd32;
        req_snap(lat);
        read_snap(2'd0, v);
        checks++;
        if (v !== 16'h8010) begin
            errors++;
            $display("FAIL pos_no_saturate: pos0 got %h required 8010", v);
        end
    endtask

    task automatic test_ovf();
        int          lat;
        logic [15:0] v;
        do_reset(8'h00, 8'h00, 8'h00, 8'h00);
        cnt[2] = 8'h5F;
        cnt[3] = 8'h64;
        wait_round();
        checks++;
        if (ovf !== OVF_EXP) begin
            errors++;
            $display("FAIL ovf_set: got %b required %b", ovf, OVF_EXP);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ovf !== OVF_EXP) begin
            errors++;
            $display("FAIL ovf_sticky: got %b required %b", ovf, OVF_EXP);
        end
        req_snap(lat);
        checks++;
        if (ovf !== OVF_EXP) begin
            errors++;
            $display("FAIL ovf_at_ack: got %b required %b", ovf, OVF_EXP);
        end
        read_snap(2'd3, v);
        checks++;
        if (ovf !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0000", ovf);
        end
        checks++;
        if (v !== 16'h0064) begin
            errors++;
            $display("FAIL big_jump_pos: pos3 got %h required 0064", v);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_ack;
        do_reset(8'h05, 8'h05, 8'h05, 8'h05);
        cnt[1] = 8'h09;
        latch_req = 1'b1;
        @(negedge clk);
        latch_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({oe, busy, sel, latch_ack} !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_round: oe=%b busy=%b sel=%0d ack=%b required all 0",
                     oe, busy, sel, latch_ack);
        end
        rst = 1'b0;
        rd_sel = 2'd1;
        seen_ack = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (latch_ack === 1'b1) seen_ack = 1'b1;
        end
        checks++;
        if (seen_ack !== 1'b0) begin
            errors++;
            $display("FAIL partial_snapshot: latch_ack seen after mid-round reset, required none");
        end
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL snap_cleared: rd_data got %h required 0000", rd_data);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        latch_req = 1'b0;
        rd_sel    = 2'd0;
        for (int i = 0; i < 4; i++) cnt[i] = 8'h00;
        test_reset();
        test_wrap();
        test_latch_wait();
        test_back_to_back();
        test_no_saturate();
        test_ovf();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
